// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// The writeback stage has priority. MDU results wait in a small FIFO and
// drain into write slots that WB leaves idle. If the FIFO head keeps losing,
// a starvation counter forces a one-cycle WB stall so the head can drain.
// Optional macro REGARB_STATS_EN adds saturating 16-bit event counters
// (WB grants, MDU grants, forced stalls).
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_we,
  input  logic [4:0]                    wb_reg,
  input  logic [31:0]                   wb_data,
  input  logic                          mdu_valid,
  output logic                          mdu_ready,
  input  logic [4:0]                    mdu_reg,
  input  logic [31:0]                   mdu_data,
  output logic                          stall_wb,
  output logic                          rf_we,
  output logic [4:0]                    rf_reg,
  output logic [31:0]                   rf_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   pending_mask
`ifdef REGARB_STATS_EN
  ,
  output logic [15:0]                   stat_wb_grants,
  output logic [15:0]                   stat_mdu_grants,
  output logic [15:0]                   stat_stalls
`endif
);

  localparam int PtrW    = $clog2(FIFO_DEPTH);
  localparam int CntW    = PtrW + 1;
  localparam int StarveW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CntW-1:0]    DepthVal  = CntW'(FIFO_DEPTH);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT - 1);

  logic [4:0]            fifoReg  [FIFO_DEPTH];
  logic [31:0]           fifoData [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slotValid;
  logic [PtrW-1:0]       rdPtr;
  logic [PtrW-1:0]       wrPtr;
  logic [CntW-1:0]       count;
  logic [StarveW-1:0]    starveCnt;
  logic                  fifoEmpty;
  logic                  wbGrant;
  logic                  fifoPop;
  logic                  fifoPush;

  // Ready depends only on the current count, so a full FIFO stays not-ready
  // even on an edge where it also drains.
  assign fifoEmpty  = (count == '0);
  assign mdu_ready  = (count < DepthVal);
  assign wbGrant    = wb_we && (wb_reg != 5'd0) && !stall_wb;
  assign fifoPop    = !wbGrant && !fifoEmpty;
  // A result for r0 completes its handshake but is never stored.
  assign fifoPush   = mdu_valid && mdu_ready && (mdu_reg != 5'd0);
  assign fifo_count = count;

  // Pending mask: OR of the one-hot destinations of all occupied slots.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slotValid[i]) pending_mask[fifoReg[i]] = 1'b1;
    end
  end

  // FIFO payload storage; occupancy is tracked by slotValid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (fifoPush) begin
      fifoReg[wrPtr]  <= mdu_reg;
      fifoData[wrPtr] <= mdu_data;
    end
  end

  // FIFO pointers, occupancy count and per-slot valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      slotValid <= '0;
    end else begin
      if (fifoPop) begin
        slotValid[rdPtr] <= 1'b0;
        rdPtr            <= rdPtr + PtrW'(1);
      end
      if (fifoPush) begin
        slotValid[wrPtr] <= 1'b1;
        wrPtr            <= wrPtr + PtrW'(1);
      end
      count <= count + CntW'(fifoPush) - CntW'(fifoPop);
    end
  end

  // Write-port grant: WB first, then the FIFO head; otherwise address and data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_reg  <= '0;
      rf_data <= '0;
    end else if (wbGrant) begin
      rf_we   <= 1'b1;
      rf_reg  <= wb_reg;
      rf_data <= wb_data;
    end else if (fifoPop) begin
      rf_we   <= 1'b1;
      rf_reg  <= fifoReg[rdPtr];
      rf_data <= fifoData[rdPtr];
    end else begin
      rf_we   <= 1'b0;
    end
  end

  // Starvation tracking: count WB wins over a waiting head and force a one-cycle stall at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
      stall_wb  <= 1'b0;
    end else if (!fifoEmpty && wbGrant) begin
      if (starveCnt == StarveMax) begin
        starveCnt <= '0;
        stall_wb  <= 1'b1;
      end else begin
        starveCnt <= starveCnt + StarveW'(1);
        stall_wb  <= 1'b0;
      end
    end else begin
      starveCnt <= '0;
      stall_wb  <= 1'b0;
    end
  end

`ifdef REGARB_STATS_EN
  // Saturating event counters for WB grants, MDU grants and forced stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wb_grants  <= '0;
      stat_mdu_grants <= '0;
      stat_stalls     <= '0;
    end else begin
      if (wbGrant && stat_wb_grants != 16'hFFFF) stat_wb_grants <= stat_wb_grants + 16'd1;
      if (fifoPop && stat_mdu_grants != 16'hFFFF) stat_mdu_grants <= stat_mdu_grants + 16'd1;
      if (!fifoEmpty && wbGrant && starveCnt == StarveMax && stat_stalls != 16'hFFFF)
        stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with the default parameters
// (FIFO_DEPTH=4, STARVE_LIMIT=8).
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        stall_wb;
  logic        rf_we;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data;
  logic [2:0]  fifo_count;
  logic [31:0] pending_mask;
`ifdef REGARB_STATS_EN
  logic [15:0] stat_wb_grants;
  logic [15:0] stat_mdu_grants;
  logic [15:0] stat_stalls;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .stall_wb(stall_wb), .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data),
    .fifo_count(fifo_count), .pending_mask(pending_mask)
`ifdef REGARB_STATS_EN
    , .stat_wb_grants(stat_wb_grants), .stat_mdu_grants(stat_mdu_grants),
    .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wbWe;
    logic [4:0]  wbReg;
    logic [31:0] wbData;
    logic        mduValid;
    logic [4:0]  mduReg;
    logic [31:0] mduData;
    logic        eWe;
    logic [4:0]  eReg;
    logic [31:0] eData;
    logic        eStall;
    logic [2:0]  eCount;
    logic [31:0] eMask;
    logic        eReady;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic wwe, input logic [4:0] wr, input logic [31:0] wd,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md,
                              input logic ewe, input logic [4:0] er, input logic [31:0] ed,
                              input logic es, input logic [2:0] ec, input logic [31:0] em,
                              input logic ery);
    vec_t v;
    v.wbWe = wwe; v.wbReg = wr; v.wbData = wd;
    v.mduValid = mv; v.mduReg = mr; v.mduData = md;
    v.eWe = ewe; v.eReg = er; v.eData = ed; v.eStall = es;
    v.eCount = ec; v.eMask = em; v.eReady = ery;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ewe, input logic [4:0] er,
                          input logic [31:0] ed, input logic es, input logic [2:0] ec,
                          input logic [31:0] em, input logic ery);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(ewe));
    chk({tag, ".rf_reg"}, 32'(rf_reg), 32'(er));
    chk({tag, ".rf_data"}, rf_data, ed);
    chk({tag, ".stall_wb"}, 32'(stall_wb), 32'(es));
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(ec));
    chk({tag, ".pending_mask"}, pending_mask, em);
    chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(ery));
    chk({tag, ".no_r0_write"}, 32'(rf_we && rf_reg == 5'd0), 32'd0);
  endtask

  task automatic drive(input logic wwe, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    wb_we = wwe; wb_reg = wr; wb_data = wd;
    mdu_valid = mv; mdu_reg = mr; mdu_data = md;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // MDU-only drain
    vecs[0]  = mk(0, 0, 0,      1, 3, 32'h1A3BEE22,  0, 0, 0,             0, 1, 32'h8,    1);
    vecs[1]  = mk(0, 0, 0,      0, 0, 0,             1, 3, 32'h1A3BEE22,  0, 0, 32'h0,    1);
    vecs[2]  = mk(0, 0, 0,      0, 0, 0,             0, 3, 32'h1A3BEE22,  0, 0, 32'h0,    1);
    // WB priority over queued reg 7
    vecs[3]  = mk(0, 0, 0,      1, 7, 32'h77777777,  0, 3, 32'h1A3BEE22,  0, 1, 32'h80,   1);
    vecs[4]  = mk(1, 2, 25,     0, 0, 0,             1, 2, 32'd25,        0, 1, 32'h80,   1);
    vecs[5]  = mk(0, 0, 0,      0, 0, 0,             1, 7, 32'h77777777,  0, 0, 32'h0,    1);
    // Zero-register handling
    vecs[6]  = mk(0, 0, 0,      1, 0, 32'hDEAD,      0, 7, 32'h77777777,  0, 0, 32'h0,    1);
    vecs[7]  = mk(0, 0, 0,      1, 4, 32'h44,        0, 7, 32'h77777777,  0, 1, 32'h10,   1);
    vecs[8]  = mk(1, 0, 32'hBAD, 0, 0, 0,            1, 4, 32'h44,        0, 0, 32'h0,    1);
    vecs[9]  = mk(1, 0, 32'hBAD, 1, 0, 32'hBEEF,     0, 4, 32'h44,        0, 0, 32'h0,    1);
    // Simultaneous push and pop
    vecs[10] = mk(0, 0, 0,      1, 9, 32'h99,        0, 4, 32'h44,        0, 1, 32'h200,  1);
    vecs[11] = mk(0, 0, 0,      1, 10, 32'hAA,       1, 9, 32'h99,        0, 1, 32'h400,  1);
    vecs[12] = mk(0, 0, 0,      0, 0, 0,             1, 10, 32'hAA,       0, 0, 32'h0,    1);
    // Fill under WB pressure, refused push while full, then drain in order
    vecs[13] = mk(1, 1, 32'h100, 1, 11, 32'hB1,      1, 1, 32'h100,       0, 1, 32'h800,  1);
    vecs[14] = mk(1, 1, 32'h101, 1, 12, 32'hB2,      1, 1, 32'h101,       0, 2, 32'h1800, 1);
    vecs[15] = mk(1, 1, 32'h102, 1, 13, 32'hB3,      1, 1, 32'h102,       0, 3, 32'h3800, 1);
    vecs[16] = mk(1, 1, 32'h103, 1, 11, 32'hB4,      1, 1, 32'h103,       0, 4, 32'h3800, 0);
    vecs[17] = mk(1, 1, 32'h104, 1, 14, 32'hB5,      1, 1, 32'h104,       0, 4, 32'h3800, 0);
    vecs[18] = mk(0, 0, 0,      1, 14, 32'hB5,       1, 11, 32'hB1,       0, 3, 32'h3800, 1);
    vecs[19] = mk(0, 0, 0,      0, 0, 0,             1, 12, 32'hB2,       0, 2, 32'h2800, 1);
    vecs[20] = mk(0, 0, 0,      0, 0, 0,             1, 13, 32'hB3,       0, 1, 32'h800,  1);
    vecs[21] = mk(0, 0, 0,      0, 0, 0,             1, 11, 32'hB4,       0, 0, 32'h0,    1);
    vecs[22] = mk(0, 0, 0,      0, 0, 0,             0, 11, 32'hB4,       0, 0, 32'h0,    1);

    // Reset held with a valid MDU result presented
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 5, 32'h5555);
    repeat (2) cycle();
    chk("rst.rf_we", 32'(rf_we), 32'd0);
    chk("rst.fifo_count", 32'(fifo_count), 32'd0);
    chk("rst.pending_mask", pending_mask, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cycle();
    checkAll("post_rst", 0, 0, 0, 0, 0, 32'h0, 1);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].wbWe, vecs[i].wbReg, vecs[i].wbData,
            vecs[i].mduValid, vecs[i].mduReg, vecs[i].mduData);
      cycle();
      checkAll($sformatf("vec%0d", i), vecs[i].eWe, vecs[i].eReg, vecs[i].eData,
               vecs[i].eStall, vecs[i].eCount, vecs[i].eMask, vecs[i].eReady);
    end

    // Starvation: one queued entry, WB requests every cycle
    drive(0, 0, 0, 1, 20, 32'h2020);
    cycle();
    checkAll("starve_push", 0, 11, 32'hB4, 0, 1, 32'h0010_0000, 1);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 5, 32'h500 + 32'(k), 0, 0, 0);
      cycle();
      checkAll($sformatf("starve_win%0d", k), 1, 5, 32'h500 + 32'(k),
               (k == 8), 1, 32'h0010_0000, 1);
    end
    // Stall cycle: WB is held (same request re-presented), the head drains
    drive(1, 5, 32'h509, 0, 0, 0);
    cycle();
    checkAll("starve_drain", 1, 20, 32'h2020, 0, 0, 32'h0, 1);
    cycle();
    checkAll("starve_resume", 1, 5, 32'h509, 0, 0, 32'h0, 1);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    checkAll("starve_idle", 0, 5, 32'h509, 0, 0, 32'h0, 1);

    // Asynchronous reset mid-operation discards queued results
    drive(1, 8, 32'h808, 1, 6, 32'h606);
    cycle();
    checkAll("pre_async", 1, 8, 32'h808, 0, 1, 32'h40, 1);
    drive(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    checkAll("async_rst", 0, 0, 0, 0, 0, 32'h0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checkAll("after_async", 0, 0, 0, 0, 0, 32'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
